// File: rtl/seg_num_formatter.sv
// Sequential signed-binary to 8-digit display formatter (shift-add-3) with sign, dot,
// leading-zero blanking and error pattern; all display outputs commit on one edge.
module seg_num_formatter #(
    parameter int DATA_W = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [DATA_W-1:0] value,
    input  logic              err_in,
    input  logic              dot_valid,
    input  logic [2:0]        dot_pos,
    output logic              busy,
    output logic              done,
    output logic [4:0]        seg_data_1,
    output logic [4:0]        seg_data_2,
    output logic [4:0]        seg_data_3,
    output logic [4:0]        seg_data_4,
    output logic [4:0]        seg_data_5,
    output logic [4:0]        seg_data_6,
    output logic [4:0]        seg_data_7,
    output logic [4:0]        seg_data_8,
    output logic [7:0]        seg_data_en,
    output logic [7:0]        seg_dot_en
);
    typedef enum logic [2:0] {IDLE, ABS, CONV, FORMAT, COMMIT} state_t;
    localparam int          CNT_W   = $clog2(DATA_W + 1);
    localparam logic [4:0]  C_MINUS = 5'd12;
    localparam logic [4:0]  C_ERR   = 5'd15;
    localparam logic [4:0]  C_BLANK = 5'd16;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      val_q, val_d, mag_q, mag_d, mag_abs;
    logic [31:0]            bcd_q, bcd_d, bcd_next, mag_ext;
    logic [DATA_W-1:0]      mag_next;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dot_valid_q, dot_valid_d, neg_q, neg_d, err_q, err_d;
    logic [2:0]             dot_pos_q, dot_pos_d, msd, keep, sign_idx;
    logic [7:0][4:0]        stage_seg_q, stage_seg_d, seg_q, seg_d;
    logic [7:0]             stage_en_q, stage_en_d, stage_dot_q, stage_dot_d;
    logic [7:0]             en_q, en_d, dot_q, dot_d;
    logic                   busy_q, busy_d, done_q, done_d;

    function automatic logic [31:0] add3(input logic [31:0] b);
        logic [31:0] r;
        r = b;
        for (int i = 0; i < 8; i++)
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        return r;
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        dot_valid_d = dot_valid_q;
        dot_pos_d   = dot_pos_q;
        neg_d       = neg_q;
        err_d       = err_q;
        stage_seg_d = stage_seg_q;
        stage_en_d  = stage_en_q;
        stage_dot_d = stage_dot_q;
        seg_d       = seg_q;
        en_d        = en_q;
        dot_d       = dot_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        mag_abs = val_q[DATA_W-1] ? ({DATA_W{1'b0}} - val_q) : val_q;
        mag_ext = 32'(mag_abs);
        {bcd_next, mag_next} = {add3(bcd_q), mag_q} << 1;

        msd = 3'd0;
        for (int i = 0; i < 8; i++)
            if (bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
        keep     = (dot_valid_q && dot_pos_q > msd) ? dot_pos_q : msd;
        sign_idx = keep + 3'd1;

        case (state_q)
            IDLE: if (req) begin
                val_d       = value;
                err_d       = err_in;
                dot_valid_d = dot_valid;
                dot_pos_d   = dot_pos;
                busy_d      = 1'b1;
                state_d     = err_in ? COMMIT : ABS;
            end
            ABS: begin
                neg_d = val_q[DATA_W-1];
                if (mag_ext > 32'd99999999 ||
                    (val_q[DATA_W-1] && mag_ext > 32'd9999999) ||
                    (val_q[DATA_W-1] && dot_valid_q && dot_pos_q == 3'd7)) begin
                    err_d   = 1'b1;
                    state_d = COMMIT;
                end else begin
                    // First iteration folded in: with a cleared BCD register add-3 is a no-op,
                    // so it reduces to shifting the magnitude MSB into the BCD LSB.
                    bcd_d   = 32'(mag_abs[DATA_W-1]);
                    mag_d   = mag_abs << 1;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = bcd_next;
                mag_d = mag_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = FORMAT;
            end
            FORMAT: begin
                for (int i = 0; i < 8; i++) begin
                    if (i <= int'(keep)) begin
                        stage_seg_d[i] = {1'b0, bcd_q[4*i +: 4]};
                        stage_en_d[i]  = 1'b1;
                    end else begin
                        stage_seg_d[i] = C_BLANK;
                        stage_en_d[i]  = 1'b0;
                    end
                end
                if (neg_q) begin
                    stage_seg_d[sign_idx] = C_MINUS;
                    stage_en_d[sign_idx]  = 1'b1;
                end
                stage_dot_d = dot_valid_q ? (8'b1 << dot_pos_q) : 8'h00;
                state_d     = COMMIT;
            end
            COMMIT: begin
                if (err_q) begin
                    seg_d = {{7{C_BLANK}}, C_ERR};
                    en_d  = 8'h01;
                    dot_d = 8'h00;
                end else begin
                    seg_d = stage_seg_q;
                    en_d  = stage_en_q;
                    dot_d = stage_dot_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            val_q       <= '0;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            dot_valid_q <= 1'b0;
            dot_pos_q   <= '0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            stage_seg_q <= {8{C_BLANK}};
            stage_en_q  <= '0;
            stage_dot_q <= '0;
            seg_q       <= {8{C_BLANK}};
            en_q        <= '0;
            dot_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            val_q       <= val_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            dot_valid_q <= dot_valid_d;
            dot_pos_q   <= dot_pos_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            stage_seg_q <= stage_seg_d;
            stage_en_q  <= stage_en_d;
            stage_dot_q <= stage_dot_d;
            seg_q       <= seg_d;
            en_q        <= en_d;
            dot_q       <= dot_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign seg_data_1  = seg_q[0];
    assign seg_data_2  = seg_q[1];
    assign seg_data_3  = seg_q[2];
    assign seg_data_4  = seg_q[3];
    assign seg_data_5  = seg_q[4];
    assign seg_data_6  = seg_q[5];
    assign seg_data_7  = seg_q[6];
    assign seg_data_8  = seg_q[7];
    assign seg_data_en = en_q;
    assign seg_dot_en  = dot_q;
endmodule

// File: tb/tb_seg_num_formatter.sv
// Table-driven bench for seg_num_formatter: digit/sign/dot/error vectors with latency,
// plus hand-written sequences for busy-ignore, req held high and mid-conversion reset.
module tb_seg_num_formatter;
    localparam int DATA_W = 28;
    localparam int LAT_N  = DATA_W + 3;
    localparam int B = 16, M = 12, E = 15;

    typedef logic [39:0] seg_t;
    typedef struct {
        logic [DATA_W-1:0] value;
        logic              err;
        logic              dv;
        logic [2:0]        dp;
        seg_t              seg;
        logic [7:0]        en;
        logic [7:0]        dot;
        int                lat;
    } vec_t;

    logic              clk = 1'b0, rst_n = 1'b0, req = 1'b0, err_in = 1'b0, dot_valid = 1'b0;
    logic [DATA_W-1:0] value = '0;
    logic [2:0]        dot_pos = '0;
    logic              busy, done;
    logic [4:0]        s1, s2, s3, s4, s5, s6, s7, s8;
    logic [7:0]        seg_data_en, seg_dot_en;
    int                checks = 0, errors = 0;
    vec_t              vq[$];

    seg_num_formatter #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .value(value), .err_in(err_in),
        .dot_valid(dot_valid), .dot_pos(dot_pos), .busy(busy), .done(done),
        .seg_data_1(s1), .seg_data_2(s2), .seg_data_3(s3), .seg_data_4(s4),
        .seg_data_5(s5), .seg_data_6(s6), .seg_data_7(s7), .seg_data_8(s8),
        .seg_data_en(seg_data_en), .seg_dot_en(seg_dot_en)
    );

    always #5 clk = ~clk;

    function automatic seg_t s8f(input int d7, d6, d5, d4, d3, d2, d1, d0);
        return {5'(d7), 5'(d6), 5'(d5), 5'(d4), 5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    function automatic seg_t segs();
        return {s8, s7, s6, s5, s4, s3, s2, s1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int v, input logic e, input logic dv, input int dp,
                       input seg_t seg, input logic [7:0] en, input logic [7:0] dot, input int lat);
        vec_t t;
        t.value = DATA_W'(v); t.err = e; t.dv = dv; t.dp = 3'(dp);
        t.seg = seg; t.en = en; t.dot = dot; t.lat = lat;
        vq.push_back(t);
    endtask

    // Issues one req and returns the edge count (sampling edge = 1) at which done is seen; 0 on timeout.
    task automatic start_and_wait(input vec_t t, output int lat, output logic busy_seen);
        @(negedge clk);
        value = t.value; err_in = t.err; dot_valid = t.dv; dot_pos = t.dp; req = 1'b1;
        lat = 0; busy_seen = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                req = 1'b0;
                busy_seen = busy;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int   lat, dones, first_done, second_done;
        logic bs;
        vec_t t;

        add(0,         0, 0, 0, s8f(B,B,B,B,B,B,B,0), 8'h01, 8'h00, LAT_N);
        add(12345,     0, 0, 0, s8f(B,B,B,1,2,3,4,5), 8'h1F, 8'h00, LAT_N);
        add(-42,       0, 0, 0, s8f(B,B,B,B,B,M,4,2), 8'h07, 8'h00, LAT_N);
        add(-9999999,  0, 0, 0, s8f(M,9,9,9,9,9,9,9), 8'hFF, 8'h00, LAT_N);
        add(5,         0, 1, 2, s8f(B,B,B,B,B,0,0,5), 8'h07, 8'h04, LAT_N);
        add(100000000, 0, 0, 0, s8f(B,B,B,B,B,B,B,E), 8'h01, 8'h00, 3);
        add(7,         1, 1, 3, s8f(B,B,B,B,B,B,B,E), 8'h01, 8'h00, 2);
        add(99999999,  0, 0, 0, s8f(9,9,9,9,9,9,9,9), 8'hFF, 8'h00, LAT_N);
        add(-10000000, 0, 0, 0, s8f(B,B,B,B,B,B,B,E), 8'h01, 8'h00, 3);
        add(-5,        0, 1, 7, s8f(B,B,B,B,B,B,B,E), 8'h01, 8'h00, 3);
        add(-5,        0, 1, 3, s8f(B,B,B,M,0,0,0,5), 8'h1F, 8'h08, LAT_N);
        add(-134217728,0, 0, 0, s8f(B,B,B,B,B,B,B,E), 8'h01, 8'h00, 3);
        add(7,         0, 1, 0, s8f(B,B,B,B,B,B,B,7), 8'h01, 8'h01, LAT_N);
        add(-1,        0, 0, 0, s8f(B,B,B,B,B,B,M,1), 8'h03, 8'h00, LAT_N);
        add(10,        0, 0, 5, s8f(B,B,B,B,B,B,1,0), 8'h03, 8'h00, LAT_N);

        #12;
        check("reset_seg",  segs(), s8f(B,B,B,B,B,B,B,B));
        check("reset_en",   seg_data_en, 8'h00);
        check("reset_dot",  seg_dot_en, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vq[k]) begin
            t = vq[k];
            start_and_wait(t, lat, bs);
            check($sformatf("v%0d_busy", k), bs, 1'b1);
            check($sformatf("v%0d_latency", k), lat, t.lat);
            check($sformatf("v%0d_seg", k), segs(), t.seg);
            check($sformatf("v%0d_en", k), seg_data_en, t.en);
            check($sformatf("v%0d_dot", k), seg_dot_en, t.dot);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", k), done, 1'b0);
            check($sformatf("v%0d_idle", k), busy, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d_hold", k), {segs(), seg_data_en, seg_dot_en}, {t.seg, t.en, t.dot});
        end

        // req pulsed while busy must be ignored: one done, first value shown.
        @(negedge clk);
        value = DATA_W'(3); err_in = 0; dot_valid = 0; req = 1'b1;
        dones = 0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            req = (c == 5);
            if (c == 5) value = DATA_W'(8);
            if (done) dones++;
        end
        req = 1'b0;
        check("busy_ignore_dones", dones, 1);
        check("busy_ignore_seg", segs(), s8f(B,B,B,B,B,B,B,3));

        // req held high restarts on the cycle after done.
        @(negedge clk);
        value = DATA_W'(-6); req = 1'b1;
        first_done = 0; second_done = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (first_done == 0) first_done = c;
                else begin
                    second_done = c;
                    req = 1'b0;
                    break;
                end
            end
        end
        req = 1'b0;
        check("held_first_done", first_done, LAT_N);
        check("held_second_done", second_done, 2 * LAT_N);
        check("held_seg", segs(), s8f(B,B,B,B,B,B,M,6));
        check("held_en", seg_data_en, 8'h03);
        repeat (LAT_N + 2) @(posedge clk);
        #1;
        check("held_no_third", busy, 1'b0);

        // Reset during CONV aborts without done and restores reset outputs.
        @(negedge clk);
        value = DATA_W'(123); dot_valid = 1; dot_pos = 3'd1; req = 1'b1;
        @(posedge clk); #1; req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_seg", segs(), s8f(B,B,B,B,B,B,B,B));
        check("abort_en", {seg_data_en, seg_dot_en}, 16'h0000);
        check("abort_busy", busy, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_hold_seg", segs(), s8f(B,B,B,B,B,B,B,B));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
